// File: rtl/axi_vec_pkg.sv
// Shared AXI constants, in-flight tag type and address helper
// for the DDR3 vector library read/write schedulers.
package axi_vec_pkg;

    localparam logic [1:0] BURST_INCR    = 2'b01;
    localparam logic [1:0] RRESP_OKAY    = 2'b00;
    localparam logic [1:0] RRESP_SLVERR  = 2'b10;
    localparam logic [3:0] CACHE_DEFAULT = 4'b0011;

    // Tag fields sized for the default library geometry
    localparam int TAG_DST_W = 2;
    localparam int TAG_IDX_W = 10;

    typedef struct packed {
        logic [TAG_DST_W-1:0] dst;
        logic [TAG_IDX_W-1:0] idx;
    } tag_t;

    function automatic logic [63:0] vec_addr(
        input logic [63:0] base,
        input logic [31:0] idx,
        input logic [31:0] vec_bytes
    );
        return base + 64'(idx) * 64'(vec_bytes);
    endfunction

endpackage

// File: rtl/axi_vec_rd_sched_fifo.sv
// Synchronous tag FIFO holding one entry per in-flight burst,
// oldest entry presented on head.
module vec_tag_fifo
    import axi_vec_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  tag_t din,
    input  logic pop,
    output logic full,
    output logic empty,
    output tag_t head
);

    localparam int AW = $clog2(DEPTH);

    tag_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign full    = cnt == (AW+1)'(DEPTH);
    assign empty   = cnt == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + (AW+1)'(do_push)
                       - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/axi_vec_rd_sched.sv
// Round-robin read scheduler sharing one AXI read port between
// vector requesters; routes returned beats back by in-order tags.
module axi_vec_rd_sched
    import axi_vec_pkg::*;
#(
    parameter int          NUM_REQ         = 4,
    parameter int          ID_WIDTH        = 4,
    parameter int          DATA_WIDTH      = 256,
    parameter int          ADDR_WIDTH      = 32,
    parameter int          SLICE_NUM       = 2,
    parameter int          VEC_NUM         = 1024,
    parameter logic [63:0] BASE_ADDR       = 64'h0,
    parameter int          MAX_OUTSTANDING = 8,
    localparam int IDX_W = $clog2(VEC_NUM),
    localparam int DST_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int OST_W = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*IDX_W-1:0] req_idx,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [ADDR_WIDTH-1:0]    M_AXI_araddr,
    output logic [7:0]               M_AXI_arlen,
    output logic [2:0]               M_AXI_arsize,
    output logic [1:0]               M_AXI_arburst,
    output logic [ID_WIDTH-1:0]      M_AXI_arid,
    output logic [3:0]               M_AXI_arcache,
    output logic [1:0]               M_AXI_arlock,
    output logic [2:0]               M_AXI_arprot,
    output logic [3:0]               M_AXI_arqos,
    output logic                     M_AXI_arvalid,
    input  logic                     M_AXI_arready,
    input  logic [DATA_WIDTH-1:0]    M_AXI_rdata,
    input  logic [ID_WIDTH-1:0]      M_AXI_rid,
    input  logic                     M_AXI_rlast,
    input  logic [1:0]               M_AXI_rresp,
    input  logic                     M_AXI_rvalid,
    output logic                     M_AXI_rready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_WIDTH-1:0]    rsp_data,
    output logic [DST_W-1:0]         rsp_dst,
    output logic [IDX_W-1:0]         rsp_idx,
    output logic [7:0]               rsp_beat,
    output logic                     rsp_last,
    output logic                     rsp_err,
    output logic [OST_W-1:0]         outstanding,
    output logic                     err_id,
    output logic                     err_len,
    output logic                     err_unexp,
    output logic                     idle
);

    localparam int VEC_BYTES = SLICE_NUM * (DATA_WIDTH / 8);

    typedef enum logic {
        AR_IDLE,
        AR_HOLD
    } ar_state_t;

    ar_state_t        state;
    logic [DST_W-1:0] rr_ptr;
    logic [DST_W-1:0] win;
    logic [DST_W-1:0] rr_nxt;
    logic             found;
    logic             grant;
    logic [IDX_W-1:0] win_idx;
    logic [OST_W-1:0] ost;
    logic             ost_dec;
    logic [7:0]       beat;
    tag_t             push_tag;
    tag_t             head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             r_hs;
    logic             r_take;
    logic             id_bad;

    // First valid requester at or after the RR pointer, with wrap
    always_comb begin
        int j;
        j     = 0;
        win   = rr_ptr;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && req_valid[j]) begin
                found = 1'b1;
                win   = DST_W'(j);
            end
        end
    end

    assign rr_nxt  = (win == DST_W'(NUM_REQ - 1))
                   ? '0 : win + 1'b1;
    assign win_idx = req_idx[int'(win)*IDX_W +: IDX_W];
    assign grant   = !ARESET && (state == AR_IDLE) && found
                   && (ost < OST_W'(MAX_OUTSTANDING))
                   && !fifo_full;

    assign req_ready = grant
                     ? (NUM_REQ'(1) << win)
                     : '0;

    assign push_tag = '{dst: TAG_DST_W'(win),
                        idx: TAG_IDX_W'(win_idx)};

    assign M_AXI_arlen   = 8'(SLICE_NUM - 1);
    assign M_AXI_arsize  = 3'($clog2(DATA_WIDTH / 8));
    assign M_AXI_arburst = BURST_INCR;
    assign M_AXI_arcache = CACHE_DEFAULT;
    assign M_AXI_arlock  = 2'b00;
    assign M_AXI_arprot  = 3'b000;
    assign M_AXI_arqos   = 4'b0000;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state         <= AR_IDLE;
            M_AXI_arvalid <= 1'b0;
            M_AXI_araddr  <= '0;
            M_AXI_arid    <= '0;
            rr_ptr        <= '0;
        end else begin
            unique case (state)
                AR_IDLE: begin
                    if (grant) begin
                        M_AXI_araddr  <= ADDR_WIDTH'(vec_addr(
                            BASE_ADDR, 32'(win_idx),
                            32'(VEC_BYTES)));
                        M_AXI_arid    <= ID_WIDTH'(win);
                        M_AXI_arvalid <= 1'b1;
                        rr_ptr        <= rr_nxt;
                        state         <= AR_HOLD;
                    end
                end
                AR_HOLD: begin
                    if (M_AXI_arready) begin
                        M_AXI_arvalid <= 1'b0;
                        state         <= AR_IDLE;
                    end
                end
                default: state <= AR_IDLE;
            endcase
        end
    end

    vec_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_tags (
        .clk   (ACLK),
        .rst   (ARESET),
        .push  (grant),
        .din   (push_tag),
        .pop   (pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (head)
    );

    // Stray beats with no tag are always accepted and dropped
    assign M_AXI_rready = fifo_empty ? 1'b1 : rsp_ready;
    assign rsp_valid    = M_AXI_rvalid && !fifo_empty;
    assign r_hs         = M_AXI_rvalid && M_AXI_rready;
    assign r_take       = r_hs && !fifo_empty;
    assign rsp_last     = beat == 8'(SLICE_NUM - 1);
    assign pop          = r_take && rsp_last;
    assign ost_dec      = r_hs && M_AXI_rlast && (ost != '0);
    assign id_bad       = M_AXI_rid != ID_WIDTH'(head.dst);

    assign rsp_err  = rsp_valid
                    && (id_bad || M_AXI_rresp != RRESP_OKAY);
    assign rsp_data = M_AXI_rdata;
    assign rsp_dst  = DST_W'(head.dst);
    assign rsp_idx  = IDX_W'(head.idx);
    assign rsp_beat = beat;

    assign outstanding = ost;
    assign idle        = (state == AR_IDLE) && (ost == '0);

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            ost       <= '0;
            beat      <= '0;
            err_id    <= 1'b0;
            err_len   <= 1'b0;
            err_unexp <= 1'b0;
        end else begin
            if (grant && !ost_dec)
                ost <= ost + 1'b1;
            else if (!grant && ost_dec)
                ost <= ost - 1'b1;
            if (r_take)
                beat <= rsp_last ? '0 : beat + 1'b1;
            if (r_take && id_bad)
                err_id <= 1'b1;
            if (r_take && (M_AXI_rlast != rsp_last))
                err_len <= 1'b1;
            if (r_hs && fifo_empty)
                err_unexp <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axi_vec_rd_sched.sv
// Scoreboard bench for axi_vec_rd_sched: AR grants, RR order,
// outstanding limit, R routing, error flags and reset.
module tb_axi_vec_rd_sched;

    logic         ACLK = 1'b0;
    logic         ARESET;
    logic [3:0]   req_valid;
    logic [39:0]  req_idx;
    logic [3:0]   req_ready;
    logic [31:0]  M_AXI_araddr;
    logic [7:0]   M_AXI_arlen;
    logic [2:0]   M_AXI_arsize;
    logic [1:0]   M_AXI_arburst;
    logic [3:0]   M_AXI_arid;
    logic [3:0]   M_AXI_arcache;
    logic [1:0]   M_AXI_arlock;
    logic [2:0]   M_AXI_arprot;
    logic [3:0]   M_AXI_arqos;
    logic         M_AXI_arvalid;
    logic         M_AXI_arready;
    logic [255:0] M_AXI_rdata;
    logic [3:0]   M_AXI_rid;
    logic         M_AXI_rlast;
    logic [1:0]   M_AXI_rresp;
    logic         M_AXI_rvalid;
    logic         M_AXI_rready;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [255:0] rsp_data;
    logic [1:0]   rsp_dst;
    logic [9:0]   rsp_idx;
    logic [7:0]   rsp_beat;
    logic         rsp_last;
    logic         rsp_err;
    logic [3:0]   outstanding;
    logic         err_id;
    logic         err_len;
    logic         err_unexp;
    logic         idle;

    typedef struct {
        logic [1:0]   dst;
        logic [9:0]   idx;
        logic [7:0]   beat;
        logic         last;
        logic         err;
        logic [255:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    always #5 ACLK = ~ACLK;

    axi_vec_rd_sched dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .req_valid     (req_valid),
        .req_idx       (req_idx),
        .req_ready     (req_ready),
        .M_AXI_araddr  (M_AXI_araddr),
        .M_AXI_arlen   (M_AXI_arlen),
        .M_AXI_arsize  (M_AXI_arsize),
        .M_AXI_arburst (M_AXI_arburst),
        .M_AXI_arid    (M_AXI_arid),
        .M_AXI_arcache (M_AXI_arcache),
        .M_AXI_arlock  (M_AXI_arlock),
        .M_AXI_arprot  (M_AXI_arprot),
        .M_AXI_arqos   (M_AXI_arqos),
        .M_AXI_arvalid (M_AXI_arvalid),
        .M_AXI_arready (M_AXI_arready),
        .M_AXI_rdata   (M_AXI_rdata),
        .M_AXI_rid     (M_AXI_rid),
        .M_AXI_rlast   (M_AXI_rlast),
        .M_AXI_rresp   (M_AXI_rresp),
        .M_AXI_rvalid  (M_AXI_rvalid),
        .M_AXI_rready  (M_AXI_rready),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_dst       (rsp_dst),
        .rsp_idx       (rsp_idx),
        .rsp_beat      (rsp_beat),
        .rsp_last      (rsp_last),
        .rsp_err       (rsp_err),
        .outstanding   (outstanding),
        .err_id        (err_id),
        .err_len       (err_len),
        .err_unexp     (err_unexp),
        .idle          (idle)
    );

    function automatic logic [255:0] mk(input int s);
        return {8{32'(s) ^ 32'hA5A5_0000}};
    endfunction

    // Response monitor: every accepted beat pops the scoreboard
    always @(negedge ACLK) begin
        exp_t e;
        #3;
        if (!ARESET && rsp_valid && rsp_ready) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL rsp_extra dst=%0d idx=%0d beat=%0d",
                         rsp_dst, rsp_idx, rsp_beat);
            end else begin
                e = exp_q.pop_front();
                if ({rsp_dst, rsp_idx, rsp_beat, rsp_last, rsp_err}
                    !== {e.dst, e.idx, e.beat, e.last, e.err}
                    || rsp_data !== e.data) begin
                    tests_failed++;
                    $display("FAIL rsp_beat got d%0d i%0d b%0d l%0d e%0d %h exp d%0d i%0d b%0d l%0d e%0d %h",
                             rsp_dst, rsp_idx, rsp_beat, rsp_last,
                             rsp_err, rsp_data[31:0], e.dst, e.idx,
                             e.beat, e.last, e.err, e.data[31:0]);
                end
            end
        end
    end

    task automatic push_exp(input logic [1:0] d, input logic [9:0] i,
                            input logic [7:0] b, input logic l,
                            input logic er, input logic [255:0] x);
        exp_t e;
        e.dst = d; e.idx = i; e.beat = b;
        e.last = l; e.err = er; e.data = x;
        exp_q.push_back(e);
    endtask

    // Tasks below start and end on a falling edge
    task automatic do_reset();
        ARESET = 1'b1;
        req_valid = '0; req_idx = '0;
        M_AXI_arready = 1'b0; M_AXI_rvalid = 1'b0;
        M_AXI_rlast = 1'b0; M_AXI_rresp = '0;
        M_AXI_rid = '0; M_AXI_rdata = '0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge ACLK);
        ARESET = 1'b0;
    endtask

    task automatic run_cycles(input int n, output int g);
        g = 0;
        repeat (n) begin
            #1;
            if (|req_ready) g++;
            @(negedge ACLK);
        end
    endtask

    task automatic r_beat(input logic [3:0] id, input logic [1:0] rs,
                          input logic l, input logic [255:0] d);
        int w;
        M_AXI_rvalid = 1'b1; M_AXI_rid = id;
        M_AXI_rresp = rs; M_AXI_rlast = l; M_AXI_rdata = d;
        #3;
        w = 0;
        while (!M_AXI_rready && w < 50) begin
            @(negedge ACLK); #3; w++;
        end
        tests_run++;
        if (w >= 50) begin
            tests_failed++;
            $display("FAIL r_beat_wait rready=%0d required 1",
                     M_AXI_rready);
        end
        @(negedge ACLK);
    endtask

    task automatic test_reset();
        ARESET = 1'b1;
        req_valid = 4'hF; req_idx = '0;
        M_AXI_arready = 1'b0; M_AXI_rvalid = 1'b0;
        M_AXI_rlast = 1'b0; M_AXI_rresp = '0;
        M_AXI_rid = '0; M_AXI_rdata = '0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge ACLK);
        #1;
        tests_run++;
        if ({M_AXI_arvalid, req_ready, M_AXI_araddr, M_AXI_arid,
             outstanding, idle, err_id, err_len, err_unexp}
            !== {1'b0, 4'h0, 32'h0, 4'h0, 4'h0, 1'b1, 3'b000}) begin
            tests_failed++;
            $display("FAIL reset_state arv=%0d rdy=%h addr=%h id=%0d ost=%0d idle=%0d errs=%0d%0d%0d required 0/0/0/0/0/1/000",
                     M_AXI_arvalid, req_ready, M_AXI_araddr,
                     M_AXI_arid, outstanding, idle,
                     err_id, err_len, err_unexp);
        end
        @(negedge ACLK);
    endtask

    task automatic test_single();
        do_reset();
        req_valid = 4'b0100;
        req_idx[20 +: 10] = 10'd5;
        #1;
        tests_run++;
        if (req_ready !== 4'b0100) begin
            tests_failed++;
            $display("FAIL single_grant req_ready=%b required 0100",
                     req_ready);
        end
        @(negedge ACLK);
        req_valid = '0;
        #1;
        tests_run++;
        if ({M_AXI_arvalid, M_AXI_araddr, M_AXI_arlen, M_AXI_arid,
             M_AXI_arsize, M_AXI_arburst, M_AXI_arcache, outstanding}
            !== {1'b1, 32'h140, 8'd1, 4'd2, 3'd5, 2'b01, 4'b0011,
                 4'd1}) begin
            tests_failed++;
            $display("FAIL single_ar v=%0d a=%h len=%0d id=%0d sz=%0d bu=%0d ca=%0d ost=%0d required 1 140 1 2 5 1 3 1",
                     M_AXI_arvalid, M_AXI_araddr, M_AXI_arlen,
                     M_AXI_arid, M_AXI_arsize, M_AXI_arburst,
                     M_AXI_arcache, outstanding);
        end
        @(negedge ACLK);
        M_AXI_arready = 1'b1;
        #1;
        tests_run++;
        if (M_AXI_arvalid !== 1'b1 || M_AXI_araddr !== 32'h140) begin
            tests_failed++;
            $display("FAIL single_ar_hold v=%0d a=%h required 1 140",
                     M_AXI_arvalid, M_AXI_araddr);
        end
        @(negedge ACLK);
        M_AXI_arready = 1'b0;
        #1;
        tests_run++;
        if (M_AXI_arvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_ar_done arvalid=%0d required 0",
                     M_AXI_arvalid);
        end
        push_exp(2'd2, 10'd5, 8'd0, 1'b0, 1'b0, mk(100));
        push_exp(2'd2, 10'd5, 8'd1, 1'b1, 1'b0, mk(101));
        r_beat(4'd2, 2'b00, 1'b0, mk(100));
        #1;
        tests_run++;
        if (outstanding !== 4'd1) begin
            tests_failed++;
            $display("FAIL single_ost_mid outstanding=%0d required 1",
                     outstanding);
        end
        r_beat(4'd2, 2'b00, 1'b1, mk(101));
        M_AXI_rvalid = 1'b0;
        #1;
        tests_run++;
        if (outstanding !== 4'd0 || idle !== 1'b1
            || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL single_end ost=%0d idle=%0d left=%0d required 0 1 0",
                     outstanding, idle, exp_q.size());
        end
        @(negedge ACLK);
    endtask

    task automatic test_round_robin();
        int ar_exp[$];
        int e;
        do_reset();
        ar_exp = '{0, 1, 2, 3, 0};
        req_valid = 4'hF;
        for (int i = 0; i < 4; i++)
            req_idx[i*10 +: 10] = 10'(10 + i);
        #1;
        tests_run++;
        if (req_ready !== 4'b0001) begin
            tests_failed++;
            $display("FAIL rr_first req_ready=%b required 0001",
                     req_ready);
        end
        e = ar_exp.pop_front();
        repeat (3) begin
            @(negedge ACLK); #1;
            tests_run++;
            if ({M_AXI_arvalid, M_AXI_arid, req_ready, M_AXI_araddr}
                !== {1'b1, 4'(e), 4'h0, 32'h280}) begin
                tests_failed++;
                $display("FAIL rr_stall v=%0d id=%0d rdy=%b a=%h required 1 %0d 0000 280",
                         M_AXI_arvalid, M_AXI_arid, req_ready,
                         M_AXI_araddr, e);
            end
        end
        @(negedge ACLK);
        M_AXI_arready = 1'b1;
        #1;
        tests_run++;
        if (req_ready !== 4'h0) begin
            tests_failed++;
            $display("FAIL rr_hs_nogrant req_ready=%b required 0000",
                     req_ready);
        end
        for (int k = 1; k < 5; k++) begin
            e = ar_exp.pop_front();
            @(negedge ACLK); #1;
            tests_run++;
            if (req_ready !== 4'(1 << e)) begin
                tests_failed++;
                $display("FAIL rr_grant req_ready=%b required %b",
                         req_ready, 4'(1 << e));
            end
            @(negedge ACLK); #1;
            tests_run++;
            if ({M_AXI_arvalid, M_AXI_arid}
                !== {1'b1, 4'(e)}) begin
                tests_failed++;
                $display("FAIL rr_arid v=%0d id=%0d required 1 %0d",
                         M_AXI_arvalid, M_AXI_arid, e);
            end
        end
        @(negedge ACLK);
        req_valid = '0;
        M_AXI_arready = 1'b0;
        #1;
        tests_run++;
        if (outstanding !== 4'd5) begin
            tests_failed++;
            $display("FAIL rr_ost outstanding=%0d required 5",
                     outstanding);
        end
        @(negedge ACLK);
    endtask

    task automatic test_outstanding();
        int g;
        do_reset();
        M_AXI_arready = 1'b1;
        req_valid = 4'hF;
        for (int i = 0; i < 4; i++)
            req_idx[i*10 +: 10] = 10'(20 + i);
        run_cycles(40, g);
        #1;
        tests_run++;
        if (g != 8 || outstanding !== 4'd8
            || req_ready !== 4'h0) begin
            tests_failed++;
            $display("FAIL ost_limit grants=%0d ost=%0d rdy=%b required 8 8 0000",
                     g, outstanding, req_ready);
        end
        push_exp(2'd0, 10'd20, 8'd0, 1'b0, 1'b0, mk(200));
        push_exp(2'd0, 10'd20, 8'd1, 1'b1, 1'b0, mk(201));
        r_beat(4'd0, 2'b00, 1'b0, mk(200));
        r_beat(4'd0, 2'b00, 1'b1, mk(201));
        M_AXI_rvalid = 1'b0;
        run_cycles(20, g);
        #1;
        tests_run++;
        if (g != 1 || outstanding !== 4'd8) begin
            tests_failed++;
            $display("FAIL ost_refill grants=%0d ost=%0d required 1 8",
                     g, outstanding);
        end
        req_valid = '0;
        @(negedge ACLK);
    endtask

    task automatic test_back_to_back();
        int g;
        do_reset();
        M_AXI_arready = 1'b1;
        req_valid = 4'b1010;
        req_idx[10 +: 10] = 10'd7;
        req_idx[30 +: 10] = 10'd9;
        run_cycles(4, g);
        req_valid = '0;
        #1;
        tests_run++;
        if (g != 2 || outstanding !== 4'd2) begin
            tests_failed++;
            $display("FAIL b2b_grants grants=%0d ost=%0d required 2 2",
                     g, outstanding);
        end
        push_exp(2'd1, 10'd7, 8'd0, 1'b0, 1'b0, mk(300));
        push_exp(2'd1, 10'd7, 8'd1, 1'b1, 1'b0, mk(301));
        push_exp(2'd3, 10'd9, 8'd0, 1'b0, 1'b0, mk(302));
        push_exp(2'd3, 10'd9, 8'd1, 1'b1, 1'b0, mk(303));
        @(negedge ACLK);
        M_AXI_rvalid = 1'b1; M_AXI_rid = 4'd1; M_AXI_rresp = '0;
        M_AXI_rlast = 1'b0; M_AXI_rdata = mk(300); rsp_ready = 1'b1;
        #1;
        tests_run++;
        if (M_AXI_rready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_rready1 rready=%0d required 1",
                     M_AXI_rready);
        end
        @(negedge ACLK);
        M_AXI_rlast = 1'b1; M_AXI_rdata = mk(301); rsp_ready = 1'b0;
        #1;
        tests_run++;
        if ({M_AXI_rready, rsp_valid, rsp_beat}
            !== {1'b0, 1'b1, 8'd1}) begin
            tests_failed++;
            $display("FAIL bp_rready0 rready=%0d rsp_valid=%0d beat=%0d required 0 1 1",
                     M_AXI_rready, rsp_valid, rsp_beat);
        end
        @(negedge ACLK);
        rsp_ready = 1'b1;
        #1;
        tests_run++;
        if (M_AXI_rready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_rready2 rready=%0d required 1",
                     M_AXI_rready);
        end
        @(negedge ACLK);
        M_AXI_rid = 4'd3; M_AXI_rlast = 1'b0;
        M_AXI_rdata = mk(302); rsp_ready = 1'b0;
        #1;
        tests_run++;
        if ({M_AXI_rready, rsp_dst, rsp_idx}
            !== {1'b0, 2'd3, 10'd9}) begin
            tests_failed++;
            $display("FAIL bp_head rready=%0d dst=%0d idx=%0d required 0 3 9",
                     M_AXI_rready, rsp_dst, rsp_idx);
        end
        @(negedge ACLK);
        rsp_ready = 1'b1;
        @(negedge ACLK);
        M_AXI_rlast = 1'b1; M_AXI_rdata = mk(303);
        @(negedge ACLK);
        M_AXI_rvalid = 1'b0; M_AXI_rlast = 1'b0;
        #1;
        tests_run++;
        if (outstanding !== 4'd0 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL bp_end ost=%0d left=%0d required 0 0",
                     outstanding, exp_q.size());
        end
        @(negedge ACLK);
    endtask

    task automatic test_errors();
        int g;
        do_reset();
        M_AXI_arready = 1'b1;
        req_valid = 4'b0001;
        req_idx[0 +: 10] = 10'd3;
        run_cycles(2, g);
        req_valid = '0;
        push_exp(2'd0, 10'd3, 8'd0, 1'b0, 1'b1, mk(400));
        push_exp(2'd0, 10'd3, 8'd1, 1'b1, 1'b0, mk(401));
        r_beat(4'd1, 2'b10, 1'b0, mk(400));
        r_beat(4'd0, 2'b00, 1'b1, mk(401));
        M_AXI_rvalid = 1'b0;
        #1;
        tests_run++;
        if ({err_id, err_len, err_unexp, outstanding}
            !== {3'b100, 4'd0}) begin
            tests_failed++;
            $display("FAIL err_id_flags id=%0d len=%0d unexp=%0d ost=%0d required 1 0 0 0",
                     err_id, err_len, err_unexp, outstanding);
        end
        @(negedge ACLK);
        req_valid = 4'b0001;
        req_idx[0 +: 10] = 10'd4;
        run_cycles(2, g);
        req_valid = '0;
        push_exp(2'd0, 10'd4, 8'd0, 1'b0, 1'b0, mk(402));
        push_exp(2'd0, 10'd4, 8'd1, 1'b1, 1'b0, mk(403));
        r_beat(4'd0, 2'b00, 1'b1, mk(402));
        #1;
        tests_run++;
        if (err_len !== 1'b1) begin
            tests_failed++;
            $display("FAIL err_len_early err_len=%0d required 1",
                     err_len);
        end
        r_beat(4'd0, 2'b00, 1'b0, mk(403));
        M_AXI_rvalid = 1'b0;
        #1;
        tests_run++;
        if ({outstanding, idle, err_id, err_unexp, rsp_valid}
            !== {4'd0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL err_end ost=%0d idle=%0d err_id=%0d unexp=%0d rsp_valid=%0d required 0 1 1 0 0",
                     outstanding, idle, err_id, err_unexp,
                     rsp_valid);
        end
        @(negedge ACLK);
    endtask

    task automatic test_reset_midburst();
        int w;
        do_reset();
        M_AXI_arready = 1'b1;
        req_valid = 4'hF;
        for (int i = 0; i < 4; i++)
            req_idx[i*10 +: 10] = 10'(30 + i);
        w = 0;
        #1;
        while (outstanding !== 4'd3 && w < 20) begin
            @(negedge ACLK); #1; w++;
        end
        tests_run++;
        if (w >= 20) begin
            tests_failed++;
            $display("FAIL rst_fill outstanding=%0d required 3",
                     outstanding);
        end
        @(negedge ACLK);
        ARESET = 1'b1;
        @(negedge ACLK);
        #1;
        tests_run++;
        if ({M_AXI_arvalid, req_ready, M_AXI_araddr, M_AXI_arid,
             outstanding, idle, err_id, err_len, err_unexp,
             rsp_valid}
            !== {1'b0, 4'h0, 32'h0, 4'h0, 4'h0, 1'b1, 3'b000,
                 1'b0}) begin
            tests_failed++;
            $display("FAIL rst_mid arv=%0d rdy=%b a=%h id=%0d ost=%0d idle=%0d errs=%0d%0d%0d rv=%0d required 0 0000 0 0 0 1 000 0",
                     M_AXI_arvalid, req_ready, M_AXI_araddr,
                     M_AXI_arid, outstanding, idle, err_id,
                     err_len, err_unexp, rsp_valid);
        end
        @(negedge ACLK);
        req_valid = '0;
        M_AXI_arready = 1'b0;
        ARESET = 1'b0;
        M_AXI_rvalid = 1'b1; M_AXI_rid = 4'd0;
        M_AXI_rlast = 1'b1; M_AXI_rresp = '0;
        M_AXI_rdata = mk(500);
        #1;
        tests_run++;
        if (M_AXI_rready !== 1'b1 || rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL stray_drain rready=%0d rsp_valid=%0d required 1 0",
                     M_AXI_rready, rsp_valid);
        end
        @(negedge ACLK);
        M_AXI_rvalid = 1'b0; M_AXI_rlast = 1'b0;
        #1;
        tests_run++;
        if ({err_unexp, err_id, err_len, outstanding}
            !== {3'b100, 4'd0}) begin
            tests_failed++;
            $display("FAIL stray_flag unexp=%0d id=%0d len=%0d ost=%0d required 1 0 0 0",
                     err_unexp, err_id, err_len, outstanding);
        end
        @(negedge ACLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_outstanding();
        test_back_to_back();
        test_errors();
        test_reset_midburst();
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain left=%0d required 0",
                     exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed",
                 tests_run, tests_failed);
        $finish;
    end

endmodule
